// File: rtl/rx_phase_sync_pkg.sv
// Shared defaults, derived widths and FSM encoding for the receive symbol-timing stage.
package rx_phase_sync_pkg;

    localparam int unsigned OS_DEFAULT        = 4;
    localparam int unsigned NB_DATA_DEFAULT   = 8;
    localparam int unsigned LOG2_NSYM_DEFAULT = 10;
    localparam int unsigned NB_PHASE_DEFAULT  = $clog2(OS_DEFAULT);
    localparam int unsigned NB_ACC_DEFAULT    = NB_DATA_DEFAULT + LOG2_NSYM_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_CMP   = 2'd2,
        ST_TRACK = 2'd3
    } state_t;

endpackage

// File: rtl/rx_phase_sync_phase_energy_acc.sv
// Per-phase |sample| accumulators with a snapshot taken at the end of each symbol window.
module phase_energy_acc
    import rx_phase_sync_pkg::*;
#(
    parameter int unsigned OS       = OS_DEFAULT,
    parameter int unsigned NB_PHASE = NB_PHASE_DEFAULT,
    parameter int unsigned NB_DATA  = NB_DATA_DEFAULT,
    parameter int unsigned NB_ACC   = NB_ACC_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_enable,
    input  logic [NB_DATA-1:0]           i_sample,
    input  logic [NB_PHASE-1:0]          i_phase,
    input  logic                         i_sym_last,
    output logic                         o_window_end,
    output logic [OS-1:0][NB_ACC-1:0]    o_snap
);

    logic [NB_DATA-1:0]          w_mag;
    logic [NB_ACC-1:0]           w_mag_ext;
    logic [OS-1:0][NB_ACC-1:0]   w_next;
    logic [OS-1:0][NB_ACC-1:0]   r_acc;
    logic [OS-1:0][NB_ACC-1:0]   r_snap;

    // Two's-complement negate without saturation: -2^(NB_DATA-1) yields 2^(NB_DATA-1) unsigned.
    assign w_mag        = i_sample[NB_DATA-1] ? -i_sample : i_sample;
    assign w_mag_ext    = {{(NB_ACC-NB_DATA){1'b0}}, w_mag};
    assign o_window_end = i_enable & (i_phase == NB_PHASE'(OS-1)) & i_sym_last;
    assign o_snap       = r_snap;

    always_comb begin
        w_next = r_acc;
        for (int unsigned p = 0; p < OS; p++) begin
            if (NB_PHASE'(p) == i_phase) begin
                w_next[p] = r_acc[p] + w_mag_ext;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_snap <= '0;
        end else if (!i_enable) begin
            r_acc  <= '0;
            r_snap <= '0;
        end else if (o_window_end) begin
            r_snap <= w_next;
            r_acc  <= '0;
        end else begin
            r_acc  <= w_next;
        end
    end

endmodule

// File: rtl/rx_phase_sync.sv
// Automatic symbol-timing recovery: picks the max-energy sampling phase per window and decimates.
module rx_phase_sync
    import rx_phase_sync_pkg::*;
#(
    parameter int unsigned OS        = OS_DEFAULT,
    parameter int unsigned NB_PHASE  = NB_PHASE_DEFAULT,
    parameter int unsigned NB_DATA   = NB_DATA_DEFAULT,
    parameter int unsigned LOG2_NSYM = LOG2_NSYM_DEFAULT,
    parameter int unsigned NB_ACC    = NB_DATA + LOG2_NSYM
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic [NB_DATA-1:0]   i_sample,
    input  logic                 i_force_phase,
    input  logic [NB_PHASE-1:0]  i_phase_sel,
    output logic [NB_DATA-1:0]   o_sample,
    output logic                 o_bit,
    output logic                 o_valid,
    output logic [NB_PHASE-1:0]  o_phase,
    output logic                 o_locked
);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [NB_PHASE-1:0]         r_ph;
    logic [LOG2_NSYM-1:0]        r_symcnt;
    logic                        w_sym_last;
    logic                        w_window_end;
    logic [OS-1:0][NB_ACC-1:0]   w_snap;
    logic [NB_ACC-1:0]           w_cand;
    logic [NB_PHASE-1:0]         r_cidx;
    logic [NB_ACC-1:0]           r_best_val;
    logic [NB_PHASE-1:0]         r_best_idx;
    logic                        r_cmp_done;
    logic [NB_PHASE-1:0]         r_auto_phase;
    logic [NB_PHASE-1:0]         r_phase;
    logic                        r_locked;
    logic                        r_valid;
    logic [NB_DATA-1:0]          r_sample;
    logic                        r_bit;

    assign w_sym_last = &r_symcnt;
    assign w_cand     = w_snap[r_cidx];

    phase_energy_acc #(
        .OS       (OS),
        .NB_PHASE (NB_PHASE),
        .NB_DATA  (NB_DATA),
        .NB_ACC   (NB_ACC)
    ) u_acc (
        .clock        (clock),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_sample     (i_sample),
        .i_phase      (r_ph),
        .i_sym_last   (w_sym_last),
        .o_window_end (w_window_end),
        .o_snap       (w_snap)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ph     <= '0;
            r_symcnt <= '0;
        end else if (!i_enable) begin
            r_ph     <= '0;
            r_symcnt <= '0;
        end else begin
            r_ph <= r_ph + NB_PHASE'(1);
            if (r_ph == NB_PHASE'(OS-1)) begin
                r_symcnt <= r_symcnt + LOG2_NSYM'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!i_enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = w_window_end ? ST_CMP : ST_ACQ;
                ST_ACQ:   if (w_window_end) w_state_next = ST_CMP;
                ST_CMP:   if (r_cidx == NB_PHASE'(OS-1)) w_state_next = ST_TRACK;
                ST_TRACK: if (w_window_end) w_state_next = ST_CMP;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // One snapshot candidate per clock; strict '>' keeps the lowest index on ties.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cidx     <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_cmp_done <= 1'b0;
        end else if (!i_enable) begin
            r_cidx     <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_cmp_done <= 1'b0;
        end else if (r_state != ST_CMP) begin
            r_cidx     <= '0;
            r_cmp_done <= 1'b0;
        end else begin
            if ((r_cidx == '0) || (w_cand > r_best_val)) begin
                r_best_val <= w_cand;
                r_best_idx <= r_cidx;
            end
            r_cidx     <= r_cidx + NB_PHASE'(1);
            r_cmp_done <= (r_cidx == NB_PHASE'(OS-1));
        end
    end

    // o_phase bypasses the fresh decision so the new phase and lock land on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_auto_phase <= '0;
            r_phase      <= '0;
            r_locked     <= 1'b0;
            r_valid      <= 1'b0;
            r_sample     <= '0;
            r_bit        <= 1'b0;
        end else if (!i_enable) begin
            r_auto_phase <= '0;
            r_phase      <= '0;
            r_locked     <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            if (r_cmp_done) begin
                r_auto_phase <= r_best_idx;
                r_locked     <= 1'b1;
            end
            if (i_force_phase) begin
                r_phase <= i_phase_sel;
            end else if (r_cmp_done) begin
                r_phase <= r_best_idx;
            end else begin
                r_phase <= r_auto_phase;
            end
            if (r_ph == r_phase) begin
                r_valid  <= 1'b1;
                r_sample <= i_sample;
                r_bit    <= i_sample[NB_DATA-1];
            end else begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign o_sample = r_sample;
    assign o_bit    = r_bit;
    assign o_valid  = r_valid;
    assign o_phase  = r_phase;
    assign o_locked = r_locked;

endmodule
